// File: rtl/render_sequencer_pkg.sv
// Shared definitions for the frame render sequencer: default geometry,
// coordinate/colour widths and the sequencer state encoding.
package render_sequencer_pkg;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int COORD_W      = 9;
  localparam int RGB_W        = 16;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/render_sequencer_raster_counter.sv
// Raster-order x/y scan counter. x wraps at H_ACTIVE-1 and bumps y; the
// counter parks on the last pixel of the frame until cleared.
module raster_counter
  import render_sequencer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  input  logic   clr,
  output coord_t x,
  output coord_t y,
  output logic   at_last
);

  localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
  localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

  assign at_last = (x == X_LAST) && (y == Y_LAST);

  // Advance in raster order on inc; clear has priority; hold on the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc && !at_last) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/render_sequencer.sv
// Frame sequencer: latches object positions once per frame, scans the
// renderer in raster order and streams registered pixels over valid/ready.
module render_sequencer
  import render_sequencer_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  coord_t ball_x_in,
  input  coord_t ball_y_in,
  input  coord_t paddle_1_y_in,
  input  coord_t paddle_2_y_in,
  output coord_t ball_x,
  output coord_t ball_y,
  output coord_t paddle_1_y,
  output coord_t paddle_2_y,
  output coord_t pixel_x,
  output coord_t pixel_y,
  input  rgb_t   pixel_rgb,
  output rgb_t   px_data,
  output logic   px_valid,
  input  logic   px_ready,
  output logic   px_last,
  output logic   busy,
  output logic   frame_done
);

  state_t state, state_next;
  logic   load, accept, cnt_inc, cnt_clr, at_last;

  // A new pixel may be registered whenever the output slot is empty or draining.
  assign load   = !px_valid || px_ready;
  assign accept = px_valid && px_ready;

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .x       (pixel_x),
    .y       (pixel_y),
    .at_last (at_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and counter control.
  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LATCH;
      end
      ST_LATCH: begin
        cnt_clr    = 1'b1;
        state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (load) begin
          cnt_inc = 1'b1;
          if (at_last) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          cnt_clr    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_clr    = 1'b1;
        state_next = CONTINUOUS ? ST_LATCH : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Position latches: the renderer sees objects frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x     <= '0;
      ball_y     <= '0;
      paddle_1_y <= '0;
      paddle_2_y <= '0;
    end else if (state == ST_LATCH) begin
      ball_x     <= ball_x_in;
      ball_y     <= ball_y_in;
      paddle_1_y <= paddle_1_y_in;
      paddle_2_y <= paddle_2_y_in;
    end
  end

  // Output pixel register; contents hold while a beat is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_data  <= '0;
      px_valid <= 1'b0;
      px_last  <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (load) begin
            px_data  <= pixel_rgb;
            px_valid <= 1'b1;
            px_last  <= at_last;
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            px_valid <= 1'b0;
            px_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
